// File: rtl/bmag_uart_loader_if.sv
// Byte-in / grid-write bundle for the bmag UART loader: UART receiver bytes in,
// pusher grid-memory write port and status out.
interface bmag_uart_loader_if #(
    parameter int AWIDTH = 12,
    parameter int BWIDTH = 14
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              ui_valid;
    logic              wen;
    logic [AWIDTH-1:0] addr_out;
    logic [BWIDTH-1:0] bmag_out;
    logic              load_done;
    logic              err;

    // The loader is the master of the grid-write side and consumes the byte stream.
    modport master (
        input  rx_valid, rx_data,
        output ui_valid, wen, addr_out, bmag_out, load_done, err
    );

    modport slave (
        output rx_valid, rx_data,
        input  ui_valid, wen, addr_out, bmag_out, load_done, err
    );
endinterface

// File: rtl/bmag_uart_loader.sv
// Frames a UART byte stream (SYNC, then little-endian word pairs) into bmag
// grid writes at sequential addresses, with an inter-byte idle timeout.
module bmag_uart_loader #(
    parameter int          BWIDTH    = 14,
    parameter int          AWIDTH    = 12,
    parameter int          NUM_WORDS = 4096,
    parameter logic [7:0]  SYNC      = 8'hA5,
    parameter int          TIMEOUT   = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    bmag_uart_loader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    localparam int                TW       = $clog2(TIMEOUT + 1);
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(NUM_WORDS - 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

    // High byte bits above the word width are dropped from the stored word.
    function automatic logic [BWIDTH-1:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
        return BWIDTH'({hi, lo});
    endfunction

    function automatic logic hi_overflow(input logic [7:0] hi);
        return (hi & (8'hFF << (BWIDTH - 8))) != 8'h00;
    endfunction

    state_t            state_q, state_d;
    logic              ui_valid_q, ui_valid_d;
    logic              wen_q, wen_d;
    logic              load_done_q, load_done_d;
    logic              err_q, err_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [BWIDTH-1:0] bmag_q, bmag_d;
    logic [AWIDTH-1:0] idx_q, idx_d;
    logic [7:0]        lo_q, lo_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    always_comb begin
        state_d     = state_q;
        ui_valid_d  = ui_valid_q;
        wen_d       = 1'b0;
        load_done_d = load_done_q;
        err_d       = err_q;
        addr_d      = addr_q;
        bmag_d      = bmag_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        tmo_d       = tmo_q;
        case (state_q)
            IDLE: begin
                // Entered from the final write cycle, so ui_valid drops one cycle after wen.
                ui_valid_d = 1'b0;
                tmo_d      = '0;
                if (bus.rx_valid && bus.rx_data == SYNC) begin
                    state_d     = LO;
                    ui_valid_d  = 1'b1;
                    load_done_d = 1'b0;
                    err_d       = 1'b0;
                    idx_d       = '0;
                end
            end
            LO, HI: begin
                if (bus.rx_valid) begin
                    tmo_d = '0;
                    if (state_q == LO) begin
                        lo_d    = bus.rx_data;
                        state_d = HI;
                    end else begin
                        wen_d  = 1'b1;
                        addr_d = idx_q;
                        bmag_d = pack_word(bus.rx_data, lo_q);
                        if (hi_overflow(bus.rx_data)) err_d = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d     = IDLE;
                            load_done_d = 1'b1;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = LO;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    ui_valid_d = 1'b0;
                    tmo_d      = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ui_valid_q  <= 1'b0;
            wen_q       <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            bmag_q      <= '0;
            idx_q       <= '0;
            lo_q        <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            ui_valid_q  <= ui_valid_d;
            wen_q       <= wen_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            bmag_q      <= bmag_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.ui_valid  = ui_valid_q;
    assign bus.wen       = wen_q;
    assign bus.load_done = load_done_q;
    assign bus.err       = err_q;
    assign bus.addr_out  = addr_q;
    assign bus.bmag_out  = bmag_q;
endmodule

// File: tb/tb_bmag_uart_loader.sv
// Directed + randomized bench for bmag_uart_loader with a stream-level reference model.
module tb_bmag_uart_loader;
    localparam int         BW   = 14;
    localparam int         AW   = 12;
    localparam int         NW   = 4;
    localparam int         TO   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int   addr;
        int   data;
        logic ld;
        int   cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bmag_uart_loader_if #(.AWIDTH(AW), .BWIDTH(BW)) bus ();

    bmag_uart_loader #(
        .BWIDTH(BW), .AWIDTH(AW), .NUM_WORDS(NW), .SYNC(SYNC), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   wen_no_ui = 0;
    logic wen_prev = 1'b0;
    logic exp_err = 1'b0;
    logic exp_ld = 1'b0;

    wr_t  obs_q[$];
    logic ui_after_q[$];
    int   exp_addr_q[$];
    int   exp_data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wen_prev) ui_after_q.push_back(bus.ui_valid);
        wen_prev <= (bus.wen === 1'b1);
        if (bus.wen === 1'b1) begin
            obs_q.push_back('{addr: int'(bus.addr_out), data: int'(bus.bmag_out),
                              ld: bus.load_done, cyc: cyc});
            if (bus.ui_valid !== 1'b1) wen_no_ui <= wen_no_ui + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [7:0] hi, input logic [7:0] lo);
        return int'({hi, lo}) % (1 << BW);
    endfunction

    // Reference: a SYNC opens a session of NW little-endian words; other bytes outside are ignored.
    task automatic model(input bq_t s);
        int i = 0;
        while (i < s.size()) begin
            if (s[i] == SYNC && i + 2 * NW < s.size()) begin
                exp_err = 1'b0;
                for (int k = 0; k < NW; k++) begin
                    logic [7:0] lo, hi;
                    lo = s[i + 1 + 2 * k];
                    hi = s[i + 2 + 2 * k];
                    exp_addr_q.push_back(k);
                    exp_data_q.push_back(word_of(hi, lo));
                    if (int'(hi) >= (1 << (BW - 8))) exp_err = 1'b1;
                end
                exp_ld = 1'b1;
                i += 1 + 2 * NW;
            end else begin
                i++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        last_cyc     = cyc + 1;
    endtask

    task automatic send_stream(input bq_t s, input int from, input int maxgap);
        for (int i = from; i < s.size(); i++) send(s[i], $urandom_range(maxgap));
        idle(6);
    endtask

    function automatic bq_t rand_session(input int ngarb);
        bq_t s;
        logic [7:0] b;
        repeat (ngarb) begin
            b = 8'($urandom_range(255));
            if (b == SYNC) b = 8'h00;
            s.push_back(b);
        end
        s.push_back(SYNC);
        repeat (2 * NW) s.push_back(8'($urandom_range(255)));
        s[ngarb + 1 + $urandom_range(2 * NW - 1)] = SYNC;
        return s;
    endfunction

    task automatic check_writes(input string tag);
        chk({tag, " count"}, obs_q.size(), exp_addr_q.size());
        for (int k = 0; k < obs_q.size() && k < exp_addr_q.size(); k++) begin
            chk({tag, " addr"}, obs_q[k].addr, exp_addr_q[k]);
            chk({tag, " data"}, obs_q[k].data, exp_data_q[k]);
            chk({tag, " load_done@wen"}, obs_q[k].ld, exp_addr_q[k] == NW - 1);
            if (k < ui_after_q.size())
                chk({tag, " ui_valid after wen"}, ui_after_q[k], exp_addr_q[k] != NW - 1);
        end
        obs_q.delete();
        ui_after_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " ui_valid"}, bus.ui_valid, 0);
        chk({tag, " wen"}, bus.wen, 0);
        chk({tag, " load_done"}, bus.load_done, 0);
        chk({tag, " err"}, bus.err, 0);
        chk({tag, " addr"}, bus.addr_out, 0);
        chk({tag, " bmag"}, bus.bmag_out, 0);
    endtask

    initial begin
        bq_t s;
        int  lc;

        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(3);
        check_zero("in_reset");
        rst = 1'b0;
        idle(2);
        check_zero("after_reset");

        // Fixed example stream
        s = '{8'hA5, 8'h34, 8'h12, 8'h78, 8'h16, 8'hFF, 8'h3F, 8'h00, 8'h00};
        model(s);
        send_stream(s, 0, 1);
        lc = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].cyc : -1;
        chk("fixed last wen latency", lc, last_cyc);
        check_writes("fixed");
        chk("fixed err", bus.err, 0);
        chk("fixed load_done", bus.load_done, 1);
        chk("fixed ui_valid end", bus.ui_valid, 0);

        // Non-SYNC bytes are ignored
        s = '{8'h00, 8'h34, 8'hA4};
        send_stream(s, 0, 1);
        chk("garbage no wen", obs_q.size(), 0);
        chk("garbage ui_valid", bus.ui_valid, 0);
        chk("garbage load_done kept", bus.load_done, 1);
        chk("garbage err kept", bus.err, 0);
        s = rand_session(0);
        model(s);
        send_stream(s, 0, 2);
        check_writes("post_garbage");
        chk("post_garbage err", bus.err, exp_err);

        // Overflowing high byte
        s = '{8'hA5, 8'h02, 8'hC1};
        repeat (2 * NW - 2) s.push_back(8'($urandom_range(8'h3F)));
        model(s);
        send_stream(s, 0, 1);
        chk("ovf word0 data", exp_data_q[0], 14'h0102);
        check_writes("ovf");
        chk("ovf err", bus.err, 1);
        chk("ovf load_done", bus.load_done, 1);
        s = rand_session(0);
        model(s);
        send(SYNC, 1);
        idle(2);
        chk("resync err cleared", bus.err, 0);
        chk("resync load_done cleared", bus.load_done, 0);
        chk("resync ui_valid", bus.ui_valid, 1);
        send_stream(s, 1, 1);
        check_writes("resync");
        chk("resync err", bus.err, exp_err);

        // Back-to-back bytes, including a SYNC value as data
        for (int r = 0; r < 3; r++) begin
            s = rand_session(r);
            model(s);
            send_stream(s, 0, 0);
            check_writes("b2b");
            chk("b2b err", bus.err, exp_err);
            chk("b2b load_done", bus.load_done, 1);
        end

        // Idle timeout after one word
        s = '{8'hA5, 8'h11, 8'h22, 8'h33};
        for (int i = 0; i < s.size(); i++) send(s[i], 0);
        idle(8);
        chk("tmo ui_valid before expiry", bus.ui_valid, 1);
        idle(12);
        chk("tmo ui_valid", bus.ui_valid, 0);
        chk("tmo err", bus.err, 1);
        chk("tmo load_done", bus.load_done, 0);
        chk("tmo wen count", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk("tmo addr", obs_q[0].addr, 0);
            chk("tmo data", obs_q[0].data, 14'h2211);
        end
        obs_q.delete();
        ui_after_q.delete();
        s = rand_session(1);
        model(s);
        send_stream(s, 0, 3);
        check_writes("after_tmo");

        // Reset asserted while waiting for a high byte
        s = '{8'hA5, 8'h21, 8'h43, 8'h65, 8'h07, 8'h99};
        exp_addr_q.push_back(0);
        exp_data_q.push_back(word_of(8'h43, 8'h21));
        exp_addr_q.push_back(1);
        exp_data_q.push_back(word_of(8'h07, 8'h65));
        for (int i = 0; i < s.size(); i++) send(s[i], 1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("mid_reset");
        idle(2);
        rst = 1'b0;
        idle(4);
        check_writes("mid_reset");
        for (int r = 0; r < 3; r++) begin
            s = rand_session($urandom_range(3));
            model(s);
            send_stream(s, 0, 3);
            check_writes("after_reset");
            chk("after_reset err", bus.err, exp_err);
        end

        chk("wen only with ui_valid", wen_no_ui, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
